mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ICache/LSB arbiter in front of the single-port MemoryController.
// Define ARB_STARVE_GUARD_EN to let a starved fetch win after STARVE_LIMIT LSB grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_valid,
  output logic [31:0] ic_inst,
  input  logic        lsb_req,
  input  logic        lsb_lors,
  input  logic [5:0]  lsb_op,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_data,
  output logic        lsb_valid,
  output logic [31:0] lsb_val,
  output logic        mc_ic_ask,
  output logic [31:0] mc_ic_addr,
  input  logic        mc_ic_valid,
  input  logic [31:0] mc_ic_inst,
  output logic        mc_lsb_request,
  output logic        mc_lsb_lors,
  output logic [5:0]  mc_lsb_op,
  output logic [31:0] mc_lsb_addr,
  output logic [31:0] mc_lsb_data,
  input  logic        mc_lsb_valid,
  input  logic [31:0] mc_lsb_val
);

  typedef enum logic [1:0] {
    IDLE, BUSY_IF, BUSY_LSB, DONE
  } state_t;

  localparam logic [CNT_W-1:0] LIM =
    CNT_W'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        kill_q, kill_d;
  logic        ic_ask_q, ic_ask_d;
  logic [31:0] ic_addr_q, ic_addr_d;
  logic        ic_valid_q, ic_valid_d;
  logic [31:0] ic_inst_q, ic_inst_d;
  logic        lreq_q, lreq_d;
  logic        lors_q, lors_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] laddr_q, laddr_d;
  logic [31:0] ldata_q, ldata_d;
  logic        lvalid_q, lvalid_d;
  logic [31:0] lval_q, lval_d;

  logic [CNT_W-1:0] cnt_q;
  logic starve, go, grant_if, grant_lsb;

  assign starve    = ic_req && (cnt_q == LIM);
  assign go        = (state_q == IDLE) && !clear_in;
  assign grant_if  = go && ic_req && (starve || !lsb_req);
  assign grant_lsb = go && lsb_req && !grant_if;

`ifdef ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_if)
      cnt_d = '0;
    else if (grant_lsb)
      cnt_d = ic_req ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      cnt_q <= '0;
    else if (rdy_in)
      cnt_q <= cnt_d;
  end
`else
  assign cnt_q = '0;
`endif

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    ic_ask_d   = ic_ask_q;
    ic_addr_d  = ic_addr_q;
    ic_valid_d = 1'b0;
    ic_inst_d  = ic_inst_q;
    lreq_d     = lreq_q;
    lors_d     = lors_q;
    op_d       = op_q;
    laddr_d    = laddr_q;
    ldata_d    = ldata_q;
    lvalid_d   = 1'b0;
    lval_d     = lval_q;
    unique case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d   = BUSY_IF;
          ic_ask_d  = 1'b1;
          ic_addr_d = ic_addr;
        end else if (grant_lsb) begin
          state_d = BUSY_LSB;
          lreq_d  = 1'b1;
          lors_d  = lsb_lors;
          op_d    = lsb_op;
          laddr_d = lsb_addr;
          ldata_d = lsb_data;
        end
      end
      BUSY_IF: begin
        if (clear_in)
          kill_d = 1'b1;
        if (mc_ic_valid) begin
          state_d  = DONE;
          ic_ask_d = 1'b0;
          if (!kill_q && !clear_in) begin
            ic_valid_d = 1'b1;
            ic_inst_d  = mc_ic_inst;
          end
        end
      end
      BUSY_LSB: begin
        // stores have already changed memory, so they are never squashed
        if (clear_in && !lors_q)
          kill_d = 1'b1;
        if (mc_lsb_valid) begin
          state_d = DONE;
          lreq_d  = 1'b0;
          if (lors_q || !(kill_q || clear_in)) begin
            lvalid_d = 1'b1;
            lval_d   = mc_lsb_val;
          end
        end
      end
      DONE: begin
        kill_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      ic_ask_q   <= 1'b0;
      ic_addr_q  <= '0;
      ic_valid_q <= 1'b0;
      ic_inst_q  <= '0;
      lreq_q     <= 1'b0;
      lors_q     <= 1'b0;
      op_q       <= '0;
      laddr_q    <= '0;
      ldata_q    <= '0;
      lvalid_q   <= 1'b0;
      lval_q     <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      ic_ask_q   <= ic_ask_d;
      ic_addr_q  <= ic_addr_d;
      ic_valid_q <= ic_valid_d;
      ic_inst_q  <= ic_inst_d;
      lreq_q     <= lreq_d;
      lors_q     <= lors_d;
      op_q       <= op_d;
      laddr_q    <= laddr_d;
      ldata_q    <= ldata_d;
      lvalid_q   <= lvalid_d;
      lval_q     <= lval_d;
    end
  end

  assign ic_valid       = ic_valid_q;
  assign ic_inst        = ic_inst_q;
  assign lsb_valid      = lvalid_q;
  assign lsb_val        = lval_q;
  assign mc_ic_ask      = ic_ask_q;
  assign mc_ic_addr     = ic_addr_q;
  assign mc_lsb_request = lreq_q;
  assign mc_lsb_lors    = lors_q;
  assign mc_lsb_op      = op_q;
  assign mc_lsb_addr    = laddr_q;
  assign mc_lsb_data    = ldata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus
// hand sequences for store/clear, rdy, starvation and reset.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear_in = 1'b0;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = 32'h0000_1000;
  logic        ic_valid;
  logic [31:0] ic_inst;
  logic        lsb_req = 1'b0;
  logic        lsb_lors = 1'b0;
  logic [5:0]  lsb_op = 6'h05;
  logic [31:0] lsb_addr = 32'h0000_2000;
  logic [31:0] lsb_data = 32'h0;
  logic        lsb_valid;
  logic [31:0] lsb_val;
  logic        mc_ic_ask;
  logic [31:0] mc_ic_addr;
  logic        mc_ic_valid = 1'b0;
  logic [31:0] mc_ic_inst = 32'h00a0_0093;
  logic        mc_lsb_request;
  logic        mc_lsb_lors;
  logic [5:0]  mc_lsb_op;
  logic [31:0] mc_lsb_addr;
  logic [31:0] mc_lsb_data;
  logic        mc_lsb_valid = 1'b0;
  logic [31:0] mc_lsb_val = 32'h1122_3344;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .clear_in(clear_in),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_valid(ic_valid), .ic_inst(ic_inst),
    .lsb_req(lsb_req), .lsb_lors(lsb_lors),
    .lsb_op(lsb_op), .lsb_addr(lsb_addr),
    .lsb_data(lsb_data),
    .lsb_valid(lsb_valid), .lsb_val(lsb_val),
    .mc_ic_ask(mc_ic_ask), .mc_ic_addr(mc_ic_addr),
    .mc_ic_valid(mc_ic_valid), .mc_ic_inst(mc_ic_inst),
    .mc_lsb_request(mc_lsb_request),
    .mc_lsb_lors(mc_lsb_lors), .mc_lsb_op(mc_lsb_op),
    .mc_lsb_addr(mc_lsb_addr), .mc_lsb_data(mc_lsb_data),
    .mc_lsb_valid(mc_lsb_valid), .mc_lsb_val(mc_lsb_val)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  // in = {ic_req, lsb_req, lors, clear, mc_ic_valid, mc_lsb_valid}
  // ex = {mc_ic_ask, mc_lsb_request, ic_valid, lsb_valid}
  typedef struct packed {
    logic [5:0] in;
    logic [3:0] ex;
  } vec_t;

  vec_t vt [26];

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  initial begin
    // fetch, then simultaneous requests (LSB first)
    vt[0]  = '{6'b100000, 4'b1000};
    vt[1]  = '{6'b100000, 4'b1000};
    vt[2]  = '{6'b100010, 4'b0010};
    vt[3]  = '{6'b000000, 4'b0000};
    vt[4]  = '{6'b000000, 4'b0000};
    vt[5]  = '{6'b110000, 4'b0100};
    vt[6]  = '{6'b110001, 4'b0001};
    vt[7]  = '{6'b100000, 4'b0000};
    vt[8]  = '{6'b100000, 4'b1000};
    vt[9]  = '{6'b100010, 4'b0010};
    vt[10] = '{6'b000000, 4'b0000};
    // clear with valid, clear in idle, clear mid fetch
    vt[11] = '{6'b100000, 4'b1000};
    vt[12] = '{6'b100110, 4'b0000};
    vt[13] = '{6'b000000, 4'b0000};
    vt[14] = '{6'b100100, 4'b0000};
    vt[15] = '{6'b100000, 4'b1000};
    vt[16] = '{6'b100100, 4'b1000};
    vt[17] = '{6'b100010, 4'b0000};
    vt[18] = '{6'b000000, 4'b0000};
    vt[19] = '{6'b100000, 4'b1000};
    vt[20] = '{6'b100010, 4'b0010};
    vt[21] = '{6'b000000, 4'b0000};
    // killed load
    vt[22] = '{6'b010000, 4'b0100};
    vt[23] = '{6'b010100, 4'b0100};
    vt[24] = '{6'b010001, 4'b0000};
    vt[25] = '{6'b000000, 4'b0000};

    tick;
    tick;
    chk("rst ask", 32'(mc_ic_ask), 32'd0);
    chk("rst lreq", 32'(mc_lsb_request), 32'd0);
    chk("rst icv", 32'(ic_valid), 32'd0);
    chk("rst lv", 32'(lsb_valid), 32'd0);
    chk("rst laddr", mc_lsb_addr, 32'd0);
    rst_in = 1'b1;
    tick;

    for (int i = 0; i < 26; i++) begin
      {ic_req, lsb_req, lsb_lors, clear_in,
       mc_ic_valid, mc_lsb_valid} = vt[i].in;
      tick;
      chk($sformatf("vec%0d ctrl", i),
          {28'd0, mc_ic_ask, mc_lsb_request,
           ic_valid, lsb_valid},
          {28'd0, vt[i].ex});
      if (vt[i].ex[3])
        chk($sformatf("vec%0d icaddr", i),
            mc_ic_addr, 32'h0000_1000);
      if (vt[i].ex[2])
        chk($sformatf("vec%0d laddr", i),
            mc_lsb_addr, 32'h0000_2000);
      if (vt[i].ex[1])
        chk($sformatf("vec%0d inst", i),
            ic_inst, 32'h00a0_0093);
      if (vt[i].ex[0])
        chk($sformatf("vec%0d lval", i),
            lsb_val, 32'h1122_3344);
    end
    {ic_req, lsb_req, lsb_lors, clear_in,
     mc_ic_valid, mc_lsb_valid} = 6'b0;

    // store with clear pulses: payload stable, never killed
    lsb_req  = 1'b1;
    lsb_lors = 1'b1;
    lsb_op   = 6'h2a;
    lsb_addr = 32'h0000_3000;
    lsb_data = 32'hdead_beef;
    tick;
    chk("st req", 32'(mc_lsb_request), 32'd1);
    chk("st lors", 32'(mc_lsb_lors), 32'd1);
    for (int k = 0; k < 3; k++) begin
      clear_in = (k != 1);
      tick;
      chk($sformatf("st%0d addr", k), mc_lsb_addr,
          32'h0000_3000);
      chk($sformatf("st%0d data", k), mc_lsb_data,
          32'hdead_beef);
      chk($sformatf("st%0d op", k), 32'(mc_lsb_op),
          32'h2a);
      chk($sformatf("st%0d req", k),
          32'(mc_lsb_request), 32'd1);
    end
    clear_in = 1'b1;
    mc_lsb_valid = 1'b1;
    tick;
    chk("st done lv", 32'(lsb_valid), 32'd1);
    chk("st done req", 32'(mc_lsb_request), 32'd0);
    clear_in = 1'b0;
    mc_lsb_valid = 1'b0;
    lsb_req = 1'b0;
    lsb_lors = 1'b0;
    tick;
    chk("st lv drop", 32'(lsb_valid), 32'd0);
    tick;

    // rdy_in low freezes arbitration
    rdy_in = 1'b0;
    ic_req = 1'b1;
    tick;
    tick;
    chk("rdy hold ask", 32'(mc_ic_ask), 32'd0);
    rdy_in = 1'b1;
    tick;
    chk("rdy go ask", 32'(mc_ic_ask), 32'd1);
    mc_ic_valid = 1'b1;
    tick;
    chk("rdy icv", 32'(ic_valid), 32'd1);
    mc_ic_valid = 1'b0;
    ic_req = 1'b0;
    tick;
    chk("rdy icv drop", 32'(ic_valid), 32'd0);
    tick;

    // starvation: both requesters held high
    lsb_addr = 32'h0000_2000;
    ic_req  = 1'b1;
    lsb_req = 1'b1;
    for (int g = 0; g < 10; g++) begin
      int n;
      logic exp_if;
      n = 0;
      while (!(mc_ic_ask || mc_lsb_request) && n < 8) begin
        tick;
        n++;
      end
      if (n >= 8) begin
        chk($sformatf("starve%0d timeout", g),
            32'd0, 32'd1);
        break;
      end
      exp_if = GUARD && ((g % 5) == 4);
      chk($sformatf("starve%0d isIF", g),
          32'(mc_ic_ask), 32'(exp_if));
      if (mc_ic_ask) mc_ic_valid = 1'b1;
      else           mc_lsb_valid = 1'b1;
      tick;
      mc_ic_valid = 1'b0;
      mc_lsb_valid = 1'b0;
    end
    ic_req  = 1'b0;
    lsb_req = 1'b0;
    tick;
    tick;

    // async reset in the middle of a load
    lsb_req = 1'b1;
    tick;
    chk("rst2 pre req", 32'(mc_lsb_request), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    chk("rst2 req", 32'(mc_lsb_request), 32'd0);
    chk("rst2 addr", mc_lsb_addr, 32'd0);
    chk("rst2 op", 32'(mc_lsb_op), 32'd0);
    tick;
    rst_in = 1'b1;
    tick;
    chk("rst2 regrant", 32'(mc_lsb_request), 32'd1);
    mc_lsb_valid = 1'b1;
    tick;
    chk("rst2 lv", 32'(lsb_valid), 32'd1);
    chk("rst2 lval", lsb_val, 32'h1122_3344);
    mc_lsb_valid = 1'b0;
    lsb_req = 1'b0;
    tick;
    chk("rst2 lv drop", 32'(lsb_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
